// File: rtl/frame_buffer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_arbiter_pkg
// Description : Shared types and helpers for the frame buffer arbiter.
//               A map entry names the SRAM bank and the location slot
//               inside that bank for one rotating frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_arbiter_pkg;

  // Words per frame buffer; also the stride between locations in a bank.
  localparam int DEFAULT_IMAGE_WORDS = 38400;

  // One rotating buffer: {bank[3:0], loc[3:0]}.
  typedef struct packed {
    logic [3:0] bank;
    logic [3:0] loc;
  } map_entry_t;

  // Width of a client id, never less than one bit.
  function automatic int client_id_w(input int num_clients);
    return (num_clients > 1) ? $clog2(num_clients) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_arbiter_if
// Description : Client request/return bus plus SRAM bank bus of the frame
//               buffer arbiter. The arbiter is the slave; the client/SRAM
//               side is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int NUM_BANKS   = 2,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 36,
  parameter int OFFSET_W    = 17
);
  logic [NUM_CLIENTS-1:0]          req;
  logic [NUM_CLIENTS-1:0]          wr;
  logic [NUM_CLIENTS*OFFSET_W-1:0] offset;
  logic [NUM_CLIENTS*DATA_W-1:0]   wdata;
  logic [NUM_CLIENTS-1:0]          gnt;
  logic [NUM_CLIENTS-1:0]          rvalid;
  logic [NUM_CLIENTS*DATA_W-1:0]   rdata;
  logic [NUM_BANKS-1:0]            mem_en;
  logic [NUM_BANKS-1:0]            mem_we;
  logic [NUM_BANKS*ADDR_W-1:0]     mem_addr;
  logic [NUM_BANKS*DATA_W-1:0]     mem_wdata;
  logic [NUM_BANKS*DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req, wr, offset, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, wr, offset, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_arbiter_bank_port.sv
`default_nettype none
// ============================================================================
// Module      : fba_bank_port
// Description : One SRAM bank port: picks a winner among requesting clients
//               mapped to this bank, forms the bank address, and tracks
//               outstanding reads with a {valid, client id} tag pipeline.
//               FBA_ROUND_ROBIN_EN selects rotating priority instead of
//               fixed lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module fba_bank_port
  import frame_buffer_arbiter_pkg::*;
#(
  parameter int BANK         = 0,
  parameter int NUM_CLIENTS  = 4,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int OFFSET_W     = 17,
  parameter int IMAGE_WORDS  = DEFAULT_IMAGE_WORDS,
  parameter int READ_LATENCY = 2,
  localparam int ID_W        = client_id_w(NUM_CLIENTS)
) (
  input  wire logic                            clock,
  input  wire logic                            reset,
  input  wire logic [NUM_CLIENTS-1:0]          req,
  input  wire logic [NUM_CLIENTS-1:0]          wr,
  input  wire logic [NUM_CLIENTS*OFFSET_W-1:0] offset,
  input  wire logic [NUM_CLIENTS*DATA_W-1:0]   wdata,
  input  wire map_entry_t [NUM_CLIENTS-1:0]    map,
  output logic      [NUM_CLIENTS-1:0]          gnt,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic      [ADDR_W-1:0]               mem_addr,
  output logic      [DATA_W-1:0]               mem_wdata,
  output logic                                 ret_valid,
  output logic      [ID_W-1:0]                 ret_id
);

  logic [NUM_CLIENTS-1:0]  w_elig;
  logic                    w_found;
  logic [ID_W-1:0]         w_win;
  logic [READ_LATENCY-1:0] r_tag_valid;
  logic [ID_W-1:0]         r_tag_id [READ_LATENCY];

`ifdef FBA_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_last;

  // Remember the most recent winner so priority starts just after it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= '0;
    end else if (w_found) begin
      r_last <= w_win;
    end
  end
`endif

  // Clients requesting this bank; nothing is eligible while in reset.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_elig[i] = !reset && req[i] && (map[i].bank == 4'(BANK));
    end
  end

  // Scan clients from the priority start point and take the first eligible.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
`ifdef FBA_ROUND_ROBIN_EN
      v_idx = (int'(r_last) + 1 + k) % NUM_CLIENTS;
`else
      v_idx = k;
`endif
      if (!w_found && w_elig[ID_W'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(v_idx);
      end
    end
  end

  // Drive the bank from the winner; an idle bank is all zero.
  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_found) begin
      gnt[w_win] = 1'b1;
      mem_en     = 1'b1;
      mem_we     = wr[w_win];
      // Location stride times slot plus offset, wrapping at ADDR_W bits.
      mem_addr   = ADDR_W'(map[w_win].loc) * ADDR_W'(IMAGE_WORDS)
                 + ADDR_W'(offset[w_win*OFFSET_W +: OFFSET_W]);
      mem_wdata  = wdata[w_win*DATA_W +: DATA_W];
    end
  end

  // Tag pipeline: the tag leaves exactly when the SRAM presents read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tag_valid <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_valid[0] <= w_found && !wr[w_win];
      r_tag_id[0]    <= w_win;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_tag_valid[s] <= r_tag_valid[s-1];
        r_tag_id[s]    <= r_tag_id[s-1];
      end
    end
  end

  assign ret_valid = r_tag_valid[READ_LATENCY-1];
  assign ret_id    = r_tag_id[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_arbiter
// Description : Multi-client arbiter over NUM_BANKS ZBT SRAM banks. Each
//               client owns a rotating frame buffer (bank, location); the
//               map rotates on frame_adv. Read data returns to the client
//               that issued the read. Optional macro FBA_ROUND_ROBIN_EN
//               enables round-robin priority in each bank port.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_arbiter
  import frame_buffer_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS  = 4,
  parameter int NUM_BANKS    = 2,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int OFFSET_W     = 17,
  parameter int IMAGE_WORDS  = DEFAULT_IMAGE_WORDS,
  parameter int READ_LATENCY = 2
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     frame_adv,
  frame_buffer_arbiter_if.slave         bus,
  output logic [NUM_CLIENTS*8-1:0]      debug_map
);

  localparam int ID_W = client_id_w(NUM_CLIENTS);

  map_entry_t [NUM_CLIENTS-1:0] r_map;
  logic [NUM_CLIENTS-1:0]       w_bank_gnt [NUM_BANKS];
  logic [NUM_BANKS-1:0]         w_ret_valid;
  logic [ID_W-1:0]              w_ret_id [NUM_BANKS];
  logic [NUM_CLIENTS-1:0]       w_rvalid;
  logic [DATA_W-1:0]            w_rsel [NUM_CLIENTS];
  logic [DATA_W-1:0]            r_rdata [NUM_CLIENTS];

  // Buffer map: interleaved across banks at reset, rotated left on frame_adv.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_map[i].bank <= 4'(i % NUM_BANKS);
        r_map[i].loc  <= 4'(i / NUM_BANKS);
      end
    end else if (frame_adv) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_map[i] <= r_map[(i + 1) % NUM_CLIENTS];
      end
    end
  end

  // Expose the map per client as {bank, loc}.
  always_comb begin
    debug_map = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      debug_map[i*8 +: 8] = r_map[i];
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      fba_bank_port #(
        .BANK         (b),
        .NUM_CLIENTS  (NUM_CLIENTS),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .OFFSET_W     (OFFSET_W),
        .IMAGE_WORDS  (IMAGE_WORDS),
        .READ_LATENCY (READ_LATENCY)
      ) u_port (
        .clock     (clock),
        .reset     (reset),
        .req       (bus.req),
        .wr        (bus.wr),
        .offset    (bus.offset),
        .wdata     (bus.wdata),
        .map       (r_map),
        .gnt       (w_bank_gnt[b]),
        .mem_en    (bus.mem_en[b]),
        .mem_we    (bus.mem_we[b]),
        .mem_addr  (bus.mem_addr[b*ADDR_W +: ADDR_W]),
        .mem_wdata (bus.mem_wdata[b*DATA_W +: DATA_W]),
        .ret_valid (w_ret_valid[b]),
        .ret_id    (w_ret_id[b])
      );
    end
  endgenerate

  // A client maps to one bank at a time, so per-bank grants simply merge.
  always_comb begin
    bus.gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bus.gnt = bus.gnt | w_bank_gnt[b];
    end
  end

  // Route returning tags to their issuing client; lower bank index wins.
  always_comb begin
    w_rvalid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      w_rsel[i] = '0;
    end
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (!reset && w_ret_valid[b]) begin
        w_rvalid[w_ret_id[b]] = 1'b1;
        w_rsel[w_ret_id[b]]   = bus.mem_rdata[b*DATA_W +: DATA_W];
      end
    end
  end

  // Hold the last returned word per client between pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        r_rdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (w_rvalid[i]) begin
          r_rdata[i] <= w_rsel[i];
        end
      end
    end
  end

  // Returned data is visible in the pulse cycle, then held.
  always_comb begin
    bus.rvalid = w_rvalid;
    bus.rdata  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      bus.rdata[i*DATA_W +: DATA_W] = w_rvalid[i] ? w_rsel[i] : r_rdata[i];
    end
  end

endmodule
`default_nettype wire
